// File: rtl/cpu_mem_sequencer.sv
// Multi-cycle sequencer that runs the single-cycle CPU core from one shared single-port memory.
// Optional performance counters are built when SEQ_PERF_EN is defined.
module cpu_mem_sequencer #(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [31:0]       cpu_imem_raddr,
  output logic [31:0]       cpu_imem_rdata,
  input  logic [31:0]       cpu_dmem_addr,
  input  logic              cpu_dmem_we,
  input  logic [31:0]       cpu_dmem_wdata,
  output logic [31:0]       cpu_dmem_rdata,
  input  logic              cpu_commit_halt,
  output logic              cpu_global_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              halted,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       perf_insts
);

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_FWAIT = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_DWAIT = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;

  localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

  logic [2:0]        state;
  logic [1:0]        wait_cnt;
  logic [31:0]       inst_q;
  logic [31:0]       data_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_sel;
  logic              re_c;
  logic              we_c;
  logic              en_c;
  logic [31:0]       wdata_c;

  // The address defaults to the held value so mem_addr only moves on an access.
  always_comb begin
    re_c     = 1'b0;
    we_c     = 1'b0;
    en_c     = 1'b0;
    wdata_c  = '0;
    addr_sel = addr_q;
    case (state)
      S_FETCH: begin
        if (!cpu_commit_halt && run) begin
          re_c     = 1'b1;
          addr_sel = cpu_imem_raddr[ADDR_W-1:0];
        end
      end
      S_DATA: begin
        re_c     = 1'b1;
        addr_sel = cpu_dmem_addr[ADDR_W-1:0];
      end
      S_EXEC: begin
        en_c     = 1'b1;
        we_c     = cpu_dmem_we;
        wdata_c  = cpu_dmem_wdata;
        addr_sel = cpu_dmem_addr[ADDR_W-1:0];
      end
      default: ;
    endcase
  end

  // Strobes are gated by rst so a reset aborts a pending write in the same cycle.
  assign mem_re         = rst & re_c;
  assign mem_we         = rst & we_c;
  assign cpu_global_en  = rst & en_c;
  assign mem_addr       = rst ? addr_sel : '0;
  assign mem_wdata      = rst ? wdata_c : '0;
  assign halted         = rst & (state == S_HALT);
  assign cpu_imem_rdata = inst_q;
  assign cpu_dmem_rdata = data_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      inst_q   <= '0;
      data_q   <= '0;
      addr_q   <= '0;
    end else begin
      addr_q <= addr_sel;
      case (state)
        S_FETCH: begin
          if (cpu_commit_halt) state <= S_HALT;
          else if (run)        state <= S_FWAIT;
        end
        S_FWAIT: begin
          if (wait_cnt == LAT_LAST) begin
            wait_cnt <= '0;
            inst_q   <= mem_rdata;
            state    <= S_DATA;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        S_DATA: state <= S_DWAIT;
        S_DWAIT: begin
          if (wait_cnt == LAT_LAST) begin
            wait_cnt <= '0;
            data_q   <= mem_rdata;
            state    <= S_EXEC;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        S_EXEC:  state <= S_FETCH;
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

`ifdef SEQ_PERF_EN
  logic [31:0] cycles_q;
  logic [31:0] insts_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cycles_q <= '0;
      insts_q  <= '0;
    end else begin
      if (state != S_HALT) cycles_q <= cycles_q + 32'd1;
      if (en_c)            insts_q  <= insts_q + 32'd1;
    end
  end

  assign perf_cycles = cycles_q;
  assign perf_insts  = insts_q;
`else
  assign perf_cycles = '0;
  assign perf_insts  = '0;
`endif

endmodule

// File: tb/tb_cpu_mem_sequencer.sv
// Directed bench for cpu_mem_sequencer: one instance at MEM_LAT=1 and one at MEM_LAT=3,
// each fed by a latency-accurate memory model, with a scoreboard of expected latched words.
module tb_cpu_mem_sequencer;

  logic        clk;
  logic        rst;
  logic        run;
  logic [31:0] cpu_imem_raddr;
  logic [31:0] cpu_dmem_addr;
  logic        cpu_dmem_we;
  logic [31:0] cpu_dmem_wdata;
  logic        cpu_commit_halt;
  logic        sel;

  logic [31:0] d1_imem_rdata, d1_dmem_rdata, d1_mem_addr, d1_mem_wdata, d1_mem_rdata;
  logic [31:0] d1_perf_cycles, d1_perf_insts;
  logic        d1_global_en, d1_mem_re, d1_mem_we, d1_halted;
  logic [31:0] d3_imem_rdata, d3_dmem_rdata, d3_mem_addr, d3_mem_wdata, d3_mem_rdata;
  logic [31:0] d3_perf_cycles, d3_perf_insts;
  logic        d3_global_en, d3_mem_re, d3_mem_we, d3_halted;

  logic [31:0] o_imem_rdata, o_dmem_rdata, o_mem_addr, o_mem_wdata, o_perf_cycles, o_perf_insts;
  logic        o_global_en, o_mem_re, o_mem_we, o_halted;

  int compared;
  int mismatched;
  int cyc;
  logic [31:0] exp_inst_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] exp_last_addr;

  cpu_mem_sequencer #(.MEM_LAT(1), .ADDR_W(32)) u_dut1 (
    .clk(clk), .rst(rst), .run(run),
    .cpu_imem_raddr(cpu_imem_raddr), .cpu_imem_rdata(d1_imem_rdata),
    .cpu_dmem_addr(cpu_dmem_addr), .cpu_dmem_we(cpu_dmem_we),
    .cpu_dmem_wdata(cpu_dmem_wdata), .cpu_dmem_rdata(d1_dmem_rdata),
    .cpu_commit_halt(cpu_commit_halt), .cpu_global_en(d1_global_en),
    .mem_addr(d1_mem_addr), .mem_re(d1_mem_re), .mem_we(d1_mem_we),
    .mem_wdata(d1_mem_wdata), .mem_rdata(d1_mem_rdata), .halted(d1_halted),
    .perf_cycles(d1_perf_cycles), .perf_insts(d1_perf_insts)
  );

  cpu_mem_sequencer #(.MEM_LAT(3), .ADDR_W(32)) u_dut3 (
    .clk(clk), .rst(rst), .run(run),
    .cpu_imem_raddr(cpu_imem_raddr), .cpu_imem_rdata(d3_imem_rdata),
    .cpu_dmem_addr(cpu_dmem_addr), .cpu_dmem_we(cpu_dmem_we),
    .cpu_dmem_wdata(cpu_dmem_wdata), .cpu_dmem_rdata(d3_dmem_rdata),
    .cpu_commit_halt(cpu_commit_halt), .cpu_global_en(d3_global_en),
    .mem_addr(d3_mem_addr), .mem_re(d3_mem_re), .mem_we(d3_mem_we),
    .mem_wdata(d3_mem_wdata), .mem_rdata(d3_mem_rdata), .halted(d3_halted),
    .perf_cycles(d3_perf_cycles), .perf_insts(d3_perf_insts)
  );

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Read data appears exactly MEM_LAT cycles after the strobe; other cycles return junk.
  logic [31:0] m3_p [0:2];
  always @(posedge clk) begin
    d1_mem_rdata <= d1_mem_re ? memWord(d1_mem_addr) : (32'hBAD0_0000 ^ cyc);
    m3_p[0]      <= d3_mem_re ? memWord(d3_mem_addr) : (32'hBAD3_0000 ^ cyc);
    m3_p[1]      <= m3_p[0];
    m3_p[2]      <= m3_p[1];
  end
  assign d3_mem_rdata = m3_p[2];

  always_comb begin
    o_imem_rdata  = sel ? d3_imem_rdata  : d1_imem_rdata;
    o_dmem_rdata  = sel ? d3_dmem_rdata  : d1_dmem_rdata;
    o_mem_addr    = sel ? d3_mem_addr    : d1_mem_addr;
    o_mem_wdata   = sel ? d3_mem_wdata   : d1_mem_wdata;
    o_perf_cycles = sel ? d3_perf_cycles : d1_perf_cycles;
    o_perf_insts  = sel ? d3_perf_insts  : d1_perf_insts;
    o_global_en   = sel ? d3_global_en   : d1_global_en;
    o_mem_re      = sel ? d3_mem_re      : d1_mem_re;
    o_mem_we      = sel ? d3_mem_we      : d1_mem_we;
    o_halted      = sel ? d3_halted      : d1_halted;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Holds reset for n cycles and checks every output is cleared on the last one.
  task automatic holdReset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b0;
      cpu_commit_halt = 1'b0;
      #1;
    end
    checkOutput("rst_re",     {31'd0, o_mem_re},     32'd0);
    checkOutput("rst_we",     {31'd0, o_mem_we},     32'd0);
    checkOutput("rst_en",     {31'd0, o_global_en},  32'd0);
    checkOutput("rst_halted", {31'd0, o_halted},     32'd0);
    checkOutput("rst_addr",   o_mem_addr,            32'd0);
    checkOutput("rst_wdata",  o_mem_wdata,           32'd0);
    checkOutput("rst_inst",   o_imem_rdata,          32'd0);
    checkOutput("rst_data",   o_dmem_rdata,          32'd0);
    checkOutput("rst_pcyc",   o_perf_cycles,         32'd0);
    checkOutput("rst_pins",   o_perf_insts,          32'd0);
    exp_inst_q.delete();
    exp_data_q.delete();
    exp_last_addr = 32'd0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1;
      run = 1'b0;
      #1;
      checkOutput($sformatf("idle_re_%0d", i), {31'd0, o_mem_re},    32'd0);
      checkOutput($sformatf("idle_en_%0d", i), {31'd0, o_global_en}, 32'd0);
    end
  endtask

  // Drives one instruction and checks every cycle of it against the expected schedule.
  task automatic applyStimulus(input int lat, input logic [31:0] pc, input logic [31:0] daddr,
                               input logic we, input logic [31:0] wdata,
                               input int abort_at, input bit drop_run);
    int total;
    bit exp_re, exp_en;
    total = 3 + 2 * lat;
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      if (k == 0) begin
        rst = 1'b1;
        run = 1'b1;
        cpu_imem_raddr  = pc;
        cpu_dmem_addr   = daddr;
        cpu_dmem_we     = we;
        cpu_dmem_wdata  = wdata;
        cpu_commit_halt = 1'b0;
      end else if (drop_run) begin
        run = 1'b0;
      end
      if (k == abort_at) rst = 1'b0;
      #1;
      if (k == abort_at) begin
        checkOutput("abort_re", {31'd0, o_mem_re},    32'd0);
        checkOutput("abort_we", {31'd0, o_mem_we},    32'd0);
        checkOutput("abort_en", {31'd0, o_global_en}, 32'd0);
        return;
      end
      exp_re = (k == 0) || (k == 1 + lat);
      exp_en = (k == 2 + 2 * lat);
      checkOutput($sformatf("re_pc%0h_k%0d", pc, k), {31'd0, o_mem_re},    {31'd0, exp_re});
      checkOutput($sformatf("en_pc%0h_k%0d", pc, k), {31'd0, o_global_en}, {31'd0, exp_en});
      checkOutput($sformatf("we_pc%0h_k%0d", pc, k), {31'd0, o_mem_we},    {31'd0, exp_en & we});
      if (k == 0) begin
        checkOutput("fetch_addr", o_mem_addr, pc);
        exp_inst_q.push_back(memWord(pc));
        exp_last_addr = pc;
      end else if (k == 1 + lat) begin
        checkOutput("data_addr", o_mem_addr, daddr);
        exp_data_q.push_back(memWord(daddr));
        exp_last_addr = daddr;
      end else if (exp_en) begin
        checkOutput("exec_addr", o_mem_addr, daddr);
        if (we) checkOutput("exec_wdata", o_mem_wdata, wdata);
        checkOutput("sb_inst_depth", exp_inst_q.size(), 32'd1);
        checkOutput("sb_data_depth", exp_data_q.size(), 32'd1);
        if (exp_inst_q.size() > 0) checkOutput("sb_inst", o_imem_rdata, exp_inst_q.pop_front());
        if (exp_data_q.size() > 0) checkOutput("sb_data", o_dmem_rdata, exp_data_q.pop_front());
      end else begin
        checkOutput($sformatf("hold_addr_k%0d", k), o_mem_addr, exp_last_addr);
      end
    end
  endtask

  initial begin
    compared        = 0;
    mismatched      = 0;
    cyc             = 0;
    sel             = 1'b0;
    rst             = 1'b0;
    run             = 1'b1;
    cpu_imem_raddr  = 32'd0;
    cpu_dmem_addr   = 32'd0;
    cpu_dmem_we     = 1'b0;
    cpu_dmem_wdata  = 32'd0;
    cpu_commit_halt = 1'b0;
    exp_last_addr   = 32'd0;

    $display("[TB] reset and back-to-back instructions at MEM_LAT=1");
    holdReset(3);
    applyStimulus(1, 32'h0000_0000, 32'h0000_0040, 1'b0, 32'd0, -1, 1'b0);
    applyStimulus(1, 32'h0000_0004, 32'h0000_0100, 1'b1, 32'hDEAD_BEEF, -1, 1'b0);

    $display("[TB] run falling mid-instruction");
    applyStimulus(1, 32'h0000_0008, 32'h0000_0044, 1'b0, 32'd0, -1, 1'b1);
    idleCycles(3);

    $display("[TB] run held low after reset");
    holdReset(2);
    idleCycles(10);
    applyStimulus(1, 32'h0000_0010, 32'h0000_0080, 1'b0, 32'd0, -1, 1'b0);

    $display("[TB] halt after third instruction");
    holdReset(2);
    applyStimulus(1, 32'h0000_0000, 32'h0000_0050, 1'b0, 32'd0, -1, 1'b0);
    applyStimulus(1, 32'h0000_0004, 32'h0000_0054, 1'b1, 32'h1234_5678, -1, 1'b0);
    applyStimulus(1, 32'h0000_0008, 32'h0000_0058, 1'b0, 32'd0, -1, 1'b0);
    @(negedge clk);
    cpu_commit_halt = 1'b1;
    cpu_imem_raddr  = 32'h0000_000C;
    #1;
    checkOutput("halt_seen_re", {31'd0, o_mem_re},    32'd0);
    checkOutput("halt_seen_en", {31'd0, o_global_en}, 32'd0);
    checkOutput("halt_seen_h",  {31'd0, o_halted},    32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("halted_%0d", i),    {31'd0, o_halted},    32'd1);
      checkOutput($sformatf("halted_re_%0d", i), {31'd0, o_mem_re},    32'd0);
      checkOutput($sformatf("halted_en_%0d", i), {31'd0, o_global_en}, 32'd0);
      checkOutput($sformatf("halted_we_%0d", i), {31'd0, o_mem_we},    32'd0);
    end
`ifdef SEQ_PERF_EN
    checkOutput("perf_insts",  o_perf_insts,  32'd3);
    checkOutput("perf_cycles", o_perf_cycles, 32'd16);
`else
    checkOutput("perf_insts",  o_perf_insts,  32'd0);
    checkOutput("perf_cycles", o_perf_cycles, 32'd0);
`endif

    $display("[TB] reset during data wait of a store");
    holdReset(2);
    applyStimulus(1, 32'h0000_000C, 32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 3, 1'b0);
    holdReset(2);
    applyStimulus(1, 32'h0000_0020, 32'h0000_0104, 1'b0, 32'd0, -1, 1'b0);

    $display("[TB] MEM_LAT=3 instance");
    sel = 1'b1;
    holdReset(2);
    applyStimulus(3, 32'h0000_0030, 32'h0000_0200, 1'b0, 32'd0, -1, 1'b0);
    applyStimulus(3, 32'h0000_0034, 32'h0000_0204, 1'b1, 32'hCAFE_F00D, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
